uart_rx: RTL

//  Serial-to-parallel UART receiver, 8N1, LSB first; companion to the uart_tx block.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud-select to
// clocks-per-bit table used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int unsigned BAUD_CNT_W = 11;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP,
    WAIT_HIGH
  } rx_state_e;

  function automatic logic [BAUD_CNT_W-1:0] baud_count(input logic [2:0] sel);
    case (sel)
      3'b000:  return BAUD_CNT_W'(1042);
      3'b001:  return BAUD_CNT_W'(695);
      3'b010:  return BAUD_CNT_W'(521);
      3'b011:  return BAUD_CNT_W'(261);
      3'b100:  return BAUD_CNT_W'(174);
      3'b101:  return BAUD_CNT_W'(87);
      3'b110:  return BAUD_CNT_W'(79);
      default: return BAUD_CNT_W'(39);
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the
// idle (high) level so reset never looks like a start edge.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised line, valid/ack
// byte handshake, framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  baud_rate_select,
  input  logic        Rx_Serial,
  input  logic        Rx_Ack,
  output logic [7:0]  Rx_Byte,
  output logic        Rx_Valid,
  output logic        Rx_Done,
  output logic        Rx_Active,
  output logic        Framing_Error,
  output logic        Overrun
);

  logic              rx_s;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  clk_count_q, clk_count_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [IDX_W-1:0]  bit_index_q, bit_index_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_done_q, rx_done_d;
  logic              rx_active_q, rx_active_d;
  logic              framing_error_q, framing_error_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  half_c;
  logic [CNT_W-1:0]  bit_end_c;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (Rx_Serial),
    .q   (rx_s)
  );

  assign half_c    = baud_q >> 1;
  assign bit_end_c = baud_q - CNT_W'(1);

  always_comb begin
    state_d         = state_q;
    clk_count_d     = clk_count_q;
    baud_d          = baud_q;
    bit_index_d     = bit_index_q;
    shift_d         = shift_q;
    rx_byte_d       = rx_byte_q;
    rx_valid_d      = rx_valid_q;
    rx_active_d     = rx_active_q;
    rx_done_d       = 1'b0;
    framing_error_d = 1'b0;
    overrun_d       = 1'b0;

    if (Rx_Ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        clk_count_d = '0;
        if (!rx_s) begin
          state_d     = START;
          rx_active_d = 1'b1;
          baud_d      = CNT_W'(baud_count(baud_rate_select));
        end
      end
      START: begin
        // Re-check the line at mid start bit to reject glitches.
        if (clk_count_q == half_c - CNT_W'(1)) begin
          clk_count_d = '0;
          if (!rx_s) begin
            state_d     = DATA;
            bit_index_d = '0;
          end else begin
            state_d     = IDLE;
            rx_active_d = 1'b0;
          end
        end else begin
          clk_count_d = clk_count_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_count_q == bit_end_c) begin
          clk_count_d          = '0;
          shift_d[bit_index_q] = rx_s;
          if (bit_index_q == IDX_W'(DATA_W - 1)) begin
            state_d = STOP;
          end else begin
            bit_index_d = bit_index_q + IDX_W'(1);
          end
        end else begin
          clk_count_d = clk_count_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_count_q == bit_end_c) begin
          clk_count_d = '0;
          if (rx_s) begin
            state_d    = CLEANUP;
            rx_byte_d  = shift_q;
            rx_done_d  = 1'b1;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !Rx_Ack;
          end else begin
            state_d         = WAIT_HIGH;
            framing_error_d = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + CNT_W'(1);
        end
      end
      CLEANUP: begin
        state_d     = IDLE;
        rx_active_d = 1'b0;
      end
      WAIT_HIGH: begin
        // A break or stuck-low line must not start a new frame.
        if (rx_s) begin
          state_d     = IDLE;
          rx_active_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        clk_count_d = '0;
        rx_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      clk_count_q     <= '0;
      baud_q          <= '0;
      bit_index_q     <= '0;
      shift_q         <= '0;
      rx_byte_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_done_q       <= 1'b0;
      rx_active_q     <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      clk_count_q     <= clk_count_d;
      baud_q          <= baud_d;
      bit_index_q     <= bit_index_d;
      shift_q         <= shift_d;
      rx_byte_q       <= rx_byte_d;
      rx_valid_q      <= rx_valid_d;
      rx_done_q       <= rx_done_d;
      rx_active_q     <= rx_active_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  assign Rx_Byte       = rx_byte_q;
  assign Rx_Valid      = rx_valid_q;
  assign Rx_Done       = rx_done_q;
  assign Rx_Active     = rx_active_q;
  assign Framing_Error = framing_error_q;
  assign Overrun       = overrun_q;

endmodule
